// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, decode handoff and redirect.
// master = fetch unit; slave = memory, decode and branch-resolution side.
interface fetch_unit_if;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [63:0] o_imem_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [6:0]  o_instr_op;
    logic [63:0] o_instr_pc;
    logic        i_redirect;
    logic [63:0] i_redirect_pc;

    modport master (
        output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_op, o_instr_pc,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_instr_ready,
               i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instr, o_instr_op, o_instr_pc,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_instr_ready,
               i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order I-mem requests, buffers responses toward
// decode with their PCs, and discards responses of requests issued before a redirect.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    fetch_unit_if.master bus
);
    // state   | meaning
    // S_BOOT  | single idle cycle after reset, no requests
    // S_RUN   | normal fetching
    // S_FLUSH | dropping responses of requests issued before a redirect

    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    // Headroom for stale requests piling up under repeated redirects against slow memory.
    localparam int unsigned CNT_W = PTR_W + 8;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [31:0]      buf_instr_q [BUF_DEPTH];
    logic [63:0]      buf_pc_q    [BUF_DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [63:0]      tag_q [BUF_DEPTH];
    logic [PTR_W-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_instr_q, out_instr_d;
    logic [63:0]      out_pc_q, out_pc_d;

    logic             req_valid, accept, rsp_known, rsp_stale, push, pop;
    logic [SUM_W-1:0] live_sum;
    logic [63:0]      push_pc;
    logic [1:0]       unused_redirect_lsb;

    assign unused_redirect_lsb = bus.i_redirect_pc[1:0];

    always_comb begin
        live_sum  = {1'b0, inflight_q} + SUM_W'(occ_q) - {1'b0, discard_q};
        req_valid = (state_q != S_BOOT) && !bus.i_redirect && (live_sum < SUM_W'(BUF_DEPTH));
        accept    = req_valid && bus.i_imem_req_ready;
        rsp_known = bus.i_imem_rsp_valid && (inflight_q != '0);
        rsp_stale = rsp_known && (discard_q != '0);
        push      = rsp_known && !bus.i_redirect && (discard_q == '0);
        pop       = out_valid_q && bus.i_instr_ready;
        push_pc   = tag_q[tag_head_q];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN, S_FLUSH: begin
                if (bus.i_redirect) begin
                    state_d = (discard_d != '0) ? S_FLUSH : S_RUN;
                end else if ((state_q == S_FLUSH) && (discard_d == '0)) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(rsp_known);
        discard_d  = discard_q;
        occ_d      = occ_q + OCC_W'(push) - OCC_W'(pop);
        head_d     = head_q + PTR_W'(pop);
        tail_d     = tail_q + PTR_W'(push);
        tag_head_d = tag_head_q + PTR_W'(push);
        tag_tail_d = tag_tail_q + PTR_W'(accept);

        if (bus.i_redirect) begin
            pc_d       = {bus.i_redirect_pc[63:2], 2'b00};
            discard_d  = inflight_q - CNT_W'(rsp_known);
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
            tag_head_d = '0;
            tag_tail_d = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 64'd4;
            end
            if (rsp_stale) begin
                discard_d = discard_q - CNT_W'(1);
            end
        end
    end

    // Output registers mirror the next head so the head shows one cycle after its push
    // and keeps the last word once the buffer drains.
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (bus.i_redirect) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = (occ_d != '0);
            if (occ_d != '0) begin
                if (push && (head_d == tail_q)) begin
                    out_instr_d = bus.i_imem_rsp_data;
                    out_pc_d    = push_pc;
                end else begin
                    out_instr_d = buf_instr_q[head_d];
                    out_pc_d    = buf_pc_q[head_d];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            inflight_q  <= '0;
            discard_q   <= '0;
            occ_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            tag_head_q  <= '0;
            tag_tail_q  <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= NOP;
            out_pc_q    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            discard_q   <= discard_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            tag_head_q  <= tag_head_d;
            tag_tail_q  <= tag_tail_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_instr_q[tail_q] <= bus.i_imem_rsp_data;
            buf_pc_q[tail_q]    <= push_pc;
        end
        if (accept) begin
            tag_q[tag_tail_q] <= pc_q;
        end
    end

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_addr      = pc_q;
    assign bus.o_instr_valid    = out_valid_q;
    assign bus.o_instr          = out_instr_q;
    assign bus.o_instr_op       = out_instr_q[6:0];
    assign bus.o_instr_pc       = out_pc_q;

    // A response landing on a full buffer means memory answered a request never issued.
    no_overflow_a: assert property (@(posedge i_clk) disable iff (i_rst)
        push |-> (occ_q != OCC_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based reference model plus an in-order memory responder.
module tb_fetch_unit;
    localparam int          DEPTH  = 2;
    localparam logic [63:0] RST_PC = 64'h0;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) u_dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [63:0] addr; bit stale; } pend_t;
    typedef struct { logic [31:0] ins; logic [63:0] pc; } ent_t;
    typedef struct { logic [63:0] addr; int due; } mreq_t;

    pend_t       pend[$];
    ent_t        bufq[$];
    mreq_t       memq[$];
    logic [63:0] m_pc, m_out_pc;
    logic [31:0] m_out_ins;
    bit          m_boot;
    int          cyc = 0;

    int          p_req_rdy = 100, p_ins_rdy = 100, p_redir = 0, dly_max = 0;
    bit          force_redir = 0, want_corner = 0, spurious = 0;
    logic [63:0] force_tgt = 64'h0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] ^ a[63:32]) * 32'h9E37_79B1 + 32'h13;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (pend[i]) if (!pend[i].stale) n++;
        return n;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        case ($urandom_range(3))
            0:       t = 64'hFFFF_FFFF_FFFF_FFF5;
            1:       t = 64'h0000_0000_0000_1002;
            default: t = {$urandom, $urandom};
        endcase
        return t;
    endfunction

    task automatic model_reset();
        pend.delete();
        bufq.delete();
        memq.delete();
        m_pc      = RST_PC;
        m_boot    = 1'b1;
        m_out_ins = NOP;
        m_out_pc  = RST_PC;
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model, return at next posedge+1.
    task automatic cycle(input bit do_rst);
        bit          exp_rv, redir, from_mem, spur;
        logic [63:0] tgt;
        pend_t       p;

        rst                  = do_rst;
        bus.i_imem_req_ready = ($urandom_range(99) < p_req_rdy);
        bus.i_instr_ready    = ($urandom_range(99) < p_ins_rdy);
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = $urandom;
        from_mem = 1'b0;
        spur     = 1'b0;
        if (!do_rst && memq.size() > 0 && memq[0].due <= cyc &&
            (dly_max == 0 || $urandom_range(3) != 0)) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = mem_word(memq[0].addr);
            from_mem = 1'b1;
        end else if (!do_rst && spurious && memq.size() == 0) begin
            bus.i_imem_rsp_valid = 1'b1;
            spur = 1'b1;
        end
        if (spur) spurious = 1'b0;

        redir = !do_rst && (force_redir || ($urandom_range(99) < p_redir));
        tgt   = force_redir ? force_tgt : rand_target();
        force_redir = 1'b0;
        if (!do_rst && want_corner && bus.i_imem_rsp_valid && bufq.size() > 0) begin
            redir             = 1'b1;
            bus.i_instr_ready = 1'b1;
            tgt               = rand_target();
            want_corner       = 1'b0;
        end
        bus.i_redirect    = redir;
        bus.i_redirect_pc = redir ? tgt : {$urandom, $urandom};

        @(negedge clk);
        exp_rv = !m_boot && !redir && (live_cnt() + bufq.size() < DEPTH);
        check_val("req_valid", bus.o_imem_req_valid, exp_rv);
        check_val("req_addr", bus.o_imem_addr, m_pc);
        check_val("instr_valid", bus.o_instr_valid, bufq.size() != 0);
        check_val("instr", bus.o_instr, m_out_ins);
        check_val("instr_op", bus.o_instr_op, m_out_ins[6:0]);
        check_val("instr_pc", bus.o_instr_pc, m_out_pc);

        if (do_rst) begin
            model_reset();
        end else begin
            if (from_mem) memq.delete(0);
            if (bus.o_imem_req_valid && bus.i_imem_req_ready)
                memq.push_back('{bus.o_imem_addr, cyc + 1 + $urandom_range(dly_max)});

            if (bufq.size() > 0 && bus.i_instr_ready) bufq.delete(0);
            if (bus.i_imem_rsp_valid && pend.size() > 0) begin
                p = pend.pop_front();
                if (!redir && !p.stale) bufq.push_back('{bus.i_imem_rsp_data, p.addr});
            end
            if (redir) begin
                bufq.delete();
                foreach (pend[i]) pend[i].stale = 1'b1;
                m_pc = {tgt[63:2], 2'b00};
            end else if (exp_rv && bus.i_imem_req_ready) begin
                pend.push_back('{m_pc, 1'b0});
                m_pc = m_pc + 64'd4;
            end
            if (bufq.size() > 0) begin
                m_out_ins = bufq[0].ins;
                m_out_pc  = bufq[0].pc;
            end
            m_boot = 1'b0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.i_imem_req_ready = 1'b0;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
        bus.i_instr_ready    = 1'b0;
        bus.i_redirect       = 1'b0;
        bus.i_redirect_pc    = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // boot with ideal memory; an orphan response in the boot cycle must be ignored
        spurious = 1'b1;
        repeat (16) cycle(1'b0);

        // decode backpressure, then release
        p_ins_rdy = 0;
        repeat (10) cycle(1'b0);
        p_ins_rdy = 100;
        repeat (8) cycle(1'b0);

        // memory request stall
        p_req_rdy = 0;
        repeat (3) cycle(1'b0);
        p_req_rdy = 100;

        // redirect with requests in flight
        dly_max = 3;
        repeat (4) cycle(1'b0);
        force_redir = 1'b1;
        force_tgt   = 64'h0000_0000_0000_1002;
        repeat (20) cycle(1'b0);

        // redirect coinciding with a response and a pop
        dly_max = 1;
        for (int k = 0; k < 10; k++) begin
            want_corner = 1'b1;
            repeat (20) cycle(1'b0);
        end
        want_corner = 1'b0;

        // randomized operation with occasional mid-run resets
        for (int blk = 0; blk < 16; blk++) begin
            p_req_rdy = $urandom_range(100, 30);
            p_ins_rdy = $urandom_range(100, 20);
            p_redir   = $urandom_range(8);
            dly_max   = $urandom_range(5);
            repeat (200) cycle(1'b0);
            if (blk % 4 == 3) begin
                for (int w = 0; w < 20 && memq.size() < 2; w++) cycle(1'b0);
                cycle(1'b1);
                spurious = 1'b1;
            end
        end

        p_redir = 0;
        repeat (20) cycle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=%0d exp=finished", cyc);
        $fatal(1);
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_0000_0000, the PC issued first after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the instruction buffer depth in entries (power of two, ≥2).
REQ-003 SHALL have one clock and a synchronous active-high reset: i_clk, clock, rising edge; i_rst, reset, synchronous, active-high.
REQ-004 i_clk  input  1  system clock.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 o_imem_req_valid  output  1  fetch request valid.
REQ-007 i_imem_req_ready  input  1  memory accepts request.
REQ-008 o_imem_addr  output  64  fetch address, bits [1:0] always 0.
REQ-009 i_imem_rsp_valid  input  1  response valid; responses return in request order.
REQ-010 i_imem_rsp_data  input  32  fetched instruction word.
REQ-011 o_instr_valid  output  1  buffer head valid toward decode.
REQ-012 i_instr_ready  input  1  decode consumes head.
REQ-013 o_instr  output  32  head instruction word.
REQ-014 o_instr_op  output  7  o_instr[6:0], the opcode driven to the main decoder.
REQ-015 o_instr_pc  output  64  PC of head instruction.
REQ-016 i_redirect  input  1  branch/jump taken: restart fetch.
REQ-017 i_redirect_pc  input  64  redirect target; bits [1:0] ignored (treated as 0).

Function
REQ-018 FSM states: S_BOOT, S_RUN, S_FLUSH.
- Reset -> S_BOOT.
- S_BOOT -> S_RUN after exactly one cycle; no request issued in S_BOOT.
- S_RUN -> S_FLUSH on i_redirect when the adjusted in-flight count is nonzero.
- S_FLUSH -> S_RUN when the discard count reaches 0.
REQ-019 In-flight count: +1 on request accept (valid & ready); -1 on i_imem_rsp_valid; both in the same cycle means unchanged.
REQ-020 Request rule: o_imem_req_valid = 1 iff all of the following hold: state ≠ S_BOOT; !i_redirect; (in-flight count + buffer occupancy − discard count) < BUF_DEPTH.
REQ-021 Once asserted and not accepted, o_imem_req_valid and o_imem_addr SHALL hold stable, except in a cycle with i_redirect, where valid drops to 0.
REQ-022 Fetch PC register increments by 4 on each request accept; 64-bit wrap from 64'hFFFF_FFFF_FFFF_FFFC to 0.
REQ-023 On i_redirect, all of the following occur in the same cycle:
- fetch PC <= {i_redirect_pc[63:2], 2'b00};
- buffer cleared (entries and pops discarded);
- discard count <= in-flight count − i_imem_rsp_valid.
REQ-024 Response handling:
- With discard count > 0: response dropped, discard count −1.
- Otherwise: response pushed into the buffer with its PC.
- Response in the redirect cycle: always dropped.
REQ-025 Each entry's PC comes from a tag queue recording the address of each accepted request, in order.
REQ-026 Latency: a response pushed in cycle N appears on o_instr_valid/o_instr in cycle N+1; there is no combinational bypass.
REQ-027 Buffer head pops on o_instr_valid & i_instr_ready; push and pop in the same cycle are allowed at any occupancy.
REQ-028 The request rule guarantees no buffer overflow; a response arriving with the buffer full is a protocol violation, flagged by assertion.
REQ-029 When o_instr_valid = 0, o_instr, o_instr_op and o_instr_pc SHALL hold their last values.
REQ-030 Redirect with an empty pipeline: state remains S_RUN; the next request goes to the target in the following cycle.

Reset
REQ-031 While i_rst = 1 at a clock edge, the following are reset:
- fetch PC <= RESET_PC;
- buffer, in-flight count and discard count <= 0;
- state <= S_BOOT;
- o_imem_req_valid and o_instr_valid = 0;
- o_instr = 32'h0000_0013 (NOP), o_instr_pc = RESET_PC.
REQ-032 Reset mid-operation abandons all outstanding requests; responses arriving after reset with no recorded request are ignored.

Verification
REQ-033 Boot: release reset, memory always ready, 1-cycle response -> first request addr 0 in the 2nd cycle after release; then 0x4, 0x8; o_instr_pc sequence 0, 4, 8.
REQ-034 Backpressure: i_instr_ready = 0 for 10 cycles -> at most BUF_DEPTH requests outstanding plus buffered; no drop; order preserved on release.
REQ-035 Request stall: i_imem_req_ready = 0 for 3 cycles -> o_imem_addr stays 0x8 and valid stays high throughout.
REQ-036 Redirect in flight: 2 outstanding, then i_redirect with target 0x1002 -> next request addr 0x1000; both stale responses dropped; first o_instr_pc = 0x1000.
REQ-037 Same-cycle corner: i_redirect coincides with a response and a pop -> response dropped, buffer empty next cycle, discard count = in-flight − 1.
REQ-038 Reset mid-run: assert i_rst with 2 outstanding -> outputs are at their reset values next cycle, and fetching restarts at RESET_PC.
